// File: rtl/i2c_pkg.sv
// Shared types and default parameters for the I2C bus monitor.
//   i2c_bus_state_t     : bus-level state (IDLE / BUSY / FREE_WAIT)
//   DEF_FILTER_CYCLES   : default deglitch depth in clk samples
//   DEF_BUS_FREE_CYCLES : default tBUF interval in clk cycles after STOP
package i2c_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BUSY      = 2'd1,
        FREE_WAIT = 2'd2
    } i2c_bus_state_t;

    localparam int DEF_FILTER_CYCLES   = 3;
    localparam int DEF_BUS_FREE_CYCLES = 64;

endpackage

// File: rtl/i2c_line_filter.sv
// Deglitch filter and edge detector for one synchronised I2C line.
//   clk, n_rst : clock, asynchronous active-low reset
//   in_i       : synchronised line sample
//   filt_o     : deglitched line (resets high, the idle bus level)
//   rise_o     : 1-cycle pulse when filt_o goes 0->1
//   fall_o     : 1-cycle pulse when filt_o goes 1->0
// A change must be present for FILTER_CYCLES consecutive samples before it
// is accepted; it then shows on filt_o FILTER_CYCLES clk edges after it first
// appeared on in_i. Shorter glitches clear the counter and never propagate.
module i2c_line_filter
    import i2c_pkg::*;
#(
    parameter int FILTER_CYCLES = DEF_FILTER_CYCLES
) (
    input  logic clk,
    input  logic n_rst,
    input  logic in_i,
    output logic filt_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = $clog2(FILTER_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          filt_q, filt_d;
    logic          dly_q;

    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (in_i != filt_q) begin
            if (cnt_q == CW'(FILTER_CYCLES - 1)) begin
                filt_d = in_i;
                cnt_d  = '0;
            end else if (cnt_q != CW'(FILTER_CYCLES)) begin
                cnt_d = cnt_q + 1'b1;
            end else begin
                // Saturate rather than wrap.
                cnt_d = cnt_q;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q  <= '0;
            filt_q <= 1'b1;
            dly_q  <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
            dly_q  <= filt_q;
        end
    end

    assign filt_o = filt_q;
    assign rise_o = filt_q & ~dly_q;
    assign fall_o = ~filt_q & dly_q;

endmodule

// File: rtl/i2c_bus_monitor.sv
// I2C bus monitor: deglitches SCL/SDA, produces edge pulses, detects
// START / repeated START / STOP and tracks bus-busy including tBUF.
//   clk, n_rst           : clock, asynchronous active-low reset
//   en                   : 0 forces IDLE and suppresses start/stop strobes
//   scl_sync, sda_sync   : synchronised line samples
//   scl_filt, sda_filt   : deglitched lines
//   scl_rise, scl_fall   : SCL edge pulses (independent of en)
//   sda_rise, sda_fall   : SDA edge pulses (internal, also exposed)
//   start_det            : START from IDLE or FREE_WAIT (1 cycle)
//   rstart_det           : START while BUSY (1 cycle)
//   stop_det             : STOP seen (1 cycle)
//   bus_busy             : high in BUSY and FREE_WAIT
//   dbg_state_o          : current bus state, for observation
// Handshake: none; all outputs are level/pulse, every pulse lasts exactly one
// clk cycle and strobes follow their causing SDA edge pulse by one cycle.
module i2c_bus_monitor
    import i2c_pkg::*;
#(
    parameter int FILTER_CYCLES   = DEF_FILTER_CYCLES,
    parameter int BUS_FREE_CYCLES = DEF_BUS_FREE_CYCLES
) (
    input  logic           clk,
    input  logic           n_rst,
    input  logic           en,
    input  logic           scl_sync,
    input  logic           sda_sync,
    output logic           scl_filt,
    output logic           sda_filt,
    output logic           scl_rise,
    output logic           scl_fall,
    output logic           sda_rise,
    output logic           sda_fall,
    output logic           start_det,
    output logic           rstart_det,
    output logic           stop_det,
    output logic           bus_busy,
    output i2c_bus_state_t dbg_state_o
);

    localparam int FW = $clog2(BUS_FREE_CYCLES + 1);

    i2c_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_scl_filter (
        .clk    (clk),
        .n_rst  (n_rst),
        .in_i   (scl_sync),
        .filt_o (scl_filt),
        .rise_o (scl_rise),
        .fall_o (scl_fall)
    );

    i2c_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_sda_filter (
        .clk    (clk),
        .n_rst  (n_rst),
        .in_i   (sda_sync),
        .filt_o (sda_filt),
        .rise_o (sda_rise),
        .fall_o (sda_fall)
    );

    // SCL high now and in the previous cycle (scl_d = 1) is the same as
    // scl_filt high without a rise pulse. A simultaneous SCL edge thus
    // disqualifies the SDA edge as a bus condition.
    logic scl_stable_high;
    logic start_cond;
    logic stop_cond;

    assign scl_stable_high = scl_filt & ~scl_rise;
    assign start_cond      = sda_fall & scl_stable_high;
    assign stop_cond       = sda_rise & scl_stable_high;

    i2c_bus_state_t state_q;
    logic [FW-1:0]  free_cnt_q;
    logic           start_det_q;
    logic           rstart_det_q;
    logic           stop_det_q;
    logic           bus_busy_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            free_cnt_q   <= '0;
            start_det_q  <= 1'b0;
            rstart_det_q <= 1'b0;
            stop_det_q   <= 1'b0;
            bus_busy_q   <= 1'b0;
        end else if (!en) begin
            state_q      <= IDLE;
            free_cnt_q   <= '0;
            start_det_q  <= 1'b0;
            rstart_det_q <= 1'b0;
            stop_det_q   <= 1'b0;
            bus_busy_q   <= 1'b0;
        end else begin
            start_det_q  <= 1'b0;
            rstart_det_q <= 1'b0;
            stop_det_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_cond) begin
                        start_det_q <= 1'b1;
                        state_q     <= BUSY;
                        bus_busy_q  <= 1'b1;
                    end else if (stop_cond) begin
                        stop_det_q  <= 1'b1;
                    end
                end
                BUSY: begin
                    if (start_cond) begin
                        rstart_det_q <= 1'b1;
                    end else if (stop_cond) begin
                        stop_det_q   <= 1'b1;
                        state_q      <= FREE_WAIT;
                        free_cnt_q   <= '0;
                    end
                end
                FREE_WAIT: begin
                    // START wins over tBUF expiry in the same cycle.
                    if (start_cond) begin
                        start_det_q <= 1'b1;
                        state_q     <= BUSY;
                        free_cnt_q  <= '0;
                    end else if (free_cnt_q == FW'(BUS_FREE_CYCLES - 1)) begin
                        state_q     <= IDLE;
                        free_cnt_q  <= '0;
                        bus_busy_q  <= 1'b0;
                    end else begin
                        free_cnt_q  <= free_cnt_q + 1'b1;
                    end
                    if (stop_cond) begin
                        stop_det_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    free_cnt_q <= '0;
                    bus_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign start_det   = start_det_q;
    assign rstart_det  = rstart_det_q;
    assign stop_det    = stop_det_q;
    assign bus_busy    = bus_busy_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_i2c_bus_monitor.sv
module tb_i2c_bus_monitor;
    import i2c_pkg::*;

    localparam logic [2:0] EV_START  = 3'b001;
    localparam logic [2:0] EV_RSTART = 3'b010;
    localparam logic [2:0] EV_STOP   = 3'b100;

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    logic n_rst, en, scl_sync, sda_sync;
    logic scl_filt, sda_filt, scl_rise, scl_fall, sda_rise, sda_fall;
    logic start_det, rstart_det, stop_det, bus_busy;
    i2c_bus_state_t dbg_state;

    always #5 clk = ~clk;

    i2c_bus_monitor #(.FILTER_CYCLES(3), .BUS_FREE_CYCLES(64)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .en          (en),
        .scl_sync    (scl_sync),
        .sda_sync    (sda_sync),
        .scl_filt    (scl_filt),
        .sda_filt    (sda_filt),
        .scl_rise    (scl_rise),
        .scl_fall    (scl_fall),
        .sda_rise    (sda_rise),
        .sda_fall    (sda_fall),
        .start_det   (start_det),
        .rstart_det  (rstart_det),
        .stop_det    (stop_det),
        .bus_busy    (bus_busy),
        .dbg_state_o (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [2:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int n_scl_rise = 0, n_scl_fall = 0, n_sda_rise = 0, n_sda_fall = 0;
    int b_scl_fall, b_sda_fall, b_sda_rise;
    logic [2:0] mon_ev;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Strobe monitor: every strobe cycle must match the next expected event.
    always @(negedge clk) begin
        mon_ev = {stop_det, rstart_det, start_det};
        if (scl_rise) n_scl_rise++;
        if (scl_fall) n_scl_fall++;
        if (sda_rise) n_sda_rise++;
        if (sda_fall) n_sda_fall++;
        if (mon_ev != 3'b000) begin
            if (exp_q.size() == 0) check("unexpected_strobe", {29'd0, mon_ev}, 32'd0);
            else                   check("strobe", {29'd0, mon_ev}, {29'd0, exp_q.pop_front()});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic scl, input logic sda, input int n);
        scl_sync = scl;
        sda_sync = sda;
        tick(n);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_rst = 1'b0; en = 1'b1; scl_sync = 1'b1; sda_sync = 1'b1;
        tick(3);
        n_rst = 1'b1;
        tick(2);

        // Reset state
        check("rst_scl_filt", scl_filt, 1);
        check("rst_sda_filt", sda_filt, 1);
        check("rst_busy", bus_busy, 0);
        check("rst_state", dbg_state, IDLE);
        check("rst_pulses", {scl_rise, scl_fall, sda_rise, sda_fall}, 0);

        // Glitch: two low samples never reach sda_filt
        b_sda_fall = n_sda_fall;
        drive(1'b1, 1'b0, 2);
        check("glitch_mid_filt", sda_filt, 1);
        drive(1'b1, 1'b1, 6);
        check("glitch_filt", sda_filt, 1);
        check("glitch_fall_cnt", n_sda_fall - b_sda_fall, 0);
        check("glitch_busy", bus_busy, 0);

        // START: filt follows after 3 edges, strobe one edge later
        exp_q.push_back(EV_START);
        drive(1'b1, 1'b0, 2);
        check("start_filt_early", sda_filt, 1);
        tick(1);
        check("start_filt", sda_filt, 0);
        check("start_busy_early", bus_busy, 0);
        tick(1);
        check("start_busy", bus_busy, 1);
        check("start_state", dbg_state, BUSY);
        tick(1);

        // STOP then tBUF of 64 cycles from the stop_det cycle
        exp_q.push_back(EV_STOP);
        drive(1'b1, 1'b1, 4);
        check("stop_state", dbg_state, FREE_WAIT);
        tick(63);
        check("tbuf_last_busy", bus_busy, 1);
        tick(1);
        check("tbuf_free", bus_busy, 0);
        check("tbuf_state", dbg_state, IDLE);

        // Repeated START
        exp_q.push_back(EV_START);
        drive(1'b1, 1'b0, 5);
        drive(1'b0, 1'b0, 5);
        drive(1'b0, 1'b1, 5);
        drive(1'b1, 1'b1, 5);
        exp_q.push_back(EV_RSTART);
        drive(1'b1, 1'b0, 5);
        check("rstart_busy", bus_busy, 1);
        check("rstart_state", dbg_state, BUSY);

        // Simultaneous fall of SCL and SDA: edges only, no START
        drive(1'b0, 1'b0, 5);
        drive(1'b0, 1'b1, 5);
        drive(1'b1, 1'b1, 5);
        b_scl_fall = n_scl_fall;
        b_sda_fall = n_sda_fall;
        drive(1'b0, 1'b0, 5);
        check("simul_scl_fall", n_scl_fall - b_scl_fall, 1);
        check("simul_sda_fall", n_sda_fall - b_sda_fall, 1);
        check("simul_state", dbg_state, BUSY);

        // STOP, then START landing exactly on free_cnt == 63
        drive(1'b1, 1'b0, 5);
        exp_q.push_back(EV_STOP);
        drive(1'b1, 1'b1, 64);
        exp_q.push_back(EV_START);
        drive(1'b1, 1'b0, 3);
        check("race_pre_state", dbg_state, FREE_WAIT);
        tick(1);
        check("race_state", dbg_state, BUSY);
        check("race_busy", bus_busy, 1);
        tick(1);
        check("race_busy_hold", bus_busy, 1);

        // en=0: forced IDLE, strobes suppressed, edges still counted
        en = 1'b0;
        tick(1);
        check("dis_busy", bus_busy, 0);
        check("dis_state", dbg_state, IDLE);
        b_sda_rise = n_sda_rise;
        b_sda_fall = n_sda_fall;
        drive(1'b1, 1'b1, 5);
        drive(1'b1, 1'b0, 5);
        check("dis_busy_after", bus_busy, 0);
        check("dis_sda_rise", n_sda_rise - b_sda_rise, 1);
        check("dis_sda_fall", n_sda_fall - b_sda_fall, 1);

        // Re-enable: STOP from IDLE stays IDLE, then a START goes BUSY
        en = 1'b1;
        tick(1);
        exp_q.push_back(EV_STOP);
        drive(1'b1, 1'b1, 4);
        check("idle_stop_state", dbg_state, IDLE);
        tick(1);
        exp_q.push_back(EV_START);
        drive(1'b1, 1'b0, 4);
        check("reen_busy", bus_busy, 1);
        tick(1);

        // Reset mid-BUSY
        n_rst = 1'b0;
        #1;
        check("mid_rst_busy", bus_busy, 0);
        check("mid_rst_scl_filt", scl_filt, 1);
        check("mid_rst_sda_filt", sda_filt, 1);
        check("mid_rst_state", dbg_state, IDLE);
        check("mid_rst_pulses", {start_det, rstart_det, stop_det, scl_rise, scl_fall, sda_rise, sda_fall}, 0);
        scl_sync = 1'b1;
        sda_sync = 1'b1;
        tick(3);
        n_rst = 1'b1;
        tick(5);
        check("post_rst_busy", bus_busy, 0);
        check("post_rst_sda_filt", sda_filt, 1);

        check("exp_q_left", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
